rf_wb_arbiter: RTL and testbench

Write-port arbiter and destination scoreboard for the 31-entry register file (2 read ports, 1 write port; $0 hardwired zero, writes to it ignored). Shares the single write port between the main pipeline writeback stage (fixed priority, no backpressure) and the long-latency mul/div unit (valid/ready). Tracks registers reserved by in-flight mul/div operations and flags read hazards to the decode stage. A starvation timer forces a pipeline stall so that mul/div results always retire.

---
 rtl/rf_wb_arbiter_if.sv | 57 +++++
 rtl/rf_wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - write-port arbiter / scoreboard signal bundle
//
// Groups every non-clock/reset signal of rf_wb_arbiter.
//   master : pipeline + mul/div + decode side (drives requests, sees results)
//   slave  : the arbiter itself
// Signals:
//   a_wr/a_addr/a_data          pipeline writeback request (no backpressure)
//   b_valid/b_addr/b_data       mul/div result, held until b_ready
//   b_ready                     mul/div result accepted this cycle
//   sb_set/sb_set_addr          mul/div dispatch reservation
//   q_addr1/q_addr2             decode source registers
//   hazard1/hazard2             source register reserved
//   pipe_stall                  registered forced stall of the writeback stage
//   sb_err                      sticky double-reservation flag
//   wr/addr3/data3              register-file write port
interface rf_wb_arbiter_if;
    logic        a_wr;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        sb_set;
    logic [4:0]  sb_set_addr;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        pipe_stall;
    logic        sb_err;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;

    modport master (
        output a_wr, a_addr, a_data,
        output b_valid, b_addr, b_data,
        input  b_ready,
        output sb_set, sb_set_addr,
        output q_addr1, q_addr2,
        input  hazard1, hazard2,
        input  pipe_stall, sb_err,
        input  wr, addr3, data3
    );

    modport slave (
        input  a_wr, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        output b_ready,
        input  sb_set, sb_set_addr,
        input  q_addr1, q_addr2,
        output hazard1, hazard2,
        output pipe_stall, sb_err,
        output wr, addr3, data3
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with mul/div destination scoreboard
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; clears FSM, counter, scoreboard, sb_err
//   bus    rf_wb_arbiter_if.slave (see interface file for signal list)
// Parameter:
//   STARVE_LIMIT  consecutive blocked mul/div cycles before a forced stall (2..15)
module rf_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    rf_wb_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nxt;
    logic [31:1] busy;
    logic        sb_err_q;

    logic        a_req;
    logic        force_grant;
    logic        blocked;
    logic        b_accept;
    logic [31:0] busy_full;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic        dup_set;

    // Writes to $0 from the pipeline never occupy the port.
    assign a_req       = bus.a_wr & (bus.a_addr != 5'd0);
    assign force_grant = (state == S_FORCE);
    assign blocked     = bus.b_valid & a_req & ~force_grant;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state; cnt counts blocked cycles seen so far in this run
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            S_IDLE: begin
                if (blocked) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = 4'd1;
                end
            end
            S_WAIT: begin
                if (!blocked) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_FORCE;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            S_FORCE: begin
                // Single-cycle stall; the next run must start from scratch,
                // which is what keeps stall pulses STARVE_LIMIT+1 apart.
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs and write-port mux
    // ------------------------------------------------------------------
    always_comb begin
        bus.pipe_stall = force_grant;
        bus.b_ready    = force_grant | ~a_req;
        bus.wr         = 1'b0;
        bus.addr3      = 5'd0;
        bus.data3      = 32'd0;
        if (force_grant) begin
            // The pipeline holds its A write this cycle, so A is dropped.
            if (bus.b_valid) begin
                bus.wr    = 1'b1;
                bus.addr3 = bus.b_addr;
                bus.data3 = bus.b_data;
            end
        end else if (a_req) begin
            bus.wr    = 1'b1;
            bus.addr3 = bus.a_addr;
            bus.data3 = bus.a_data;
        end else if (bus.b_valid) begin
            bus.wr    = 1'b1;
            bus.addr3 = bus.b_addr;
            bus.data3 = bus.b_data;
        end
    end

    // ------------------------------------------------------------------
    // Destination scoreboard
    // ------------------------------------------------------------------
    assign b_accept  = bus.b_valid & bus.b_ready;
    // Bit 0 is a constant zero so $0 lookups need no special case.
    assign busy_full = {busy, 1'b0};
    assign set_mask  = (bus.sb_set && bus.sb_set_addr != 5'd0) ? (32'd1 << bus.sb_set_addr) : 32'd0;
    assign clr_mask  = (b_accept && bus.b_addr != 5'd0) ? (32'd1 << bus.b_addr) : 32'd0;
    assign dup_set   = |(set_mask & busy_full);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy     <= '0;
            sb_err_q <= 1'b0;
        end else begin
            // Set is applied after clear so a same-cycle set wins.
            busy <= (busy & ~clr_mask[31:1]) | set_mask[31:1];
            if (dup_set) begin
                sb_err_q <= 1'b1;
            end
        end
    end

    assign bus.sb_err  = sb_err_q;
    assign bus.hazard1 = busy_full[bus.q_addr1];
    assign bus.hazard2 = busy_full[bus.q_addr2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
module tb_rf_wb_arbiter;
    localparam int LIMIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rf_wb_arbiter_if bus ();

    rf_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: set of reserved registers, sticky error flag, and the
    // length of the current run of consecutive blocked mul/div cycles.
    bit [31:0] m_busy = '0;
    bit        m_err  = 1'b0;
    int        m_run  = 0;

    function automatic bit m_stall();
        return m_run == LIMIT;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = '0;
            m_err  = 1'b0;
            m_run  = 0;
        end else begin
            bit st, areq, brdy, bacc, blk;
            st   = m_stall();
            areq = bus.a_wr && bus.a_addr != 0;
            brdy = st || !areq;
            bacc = bus.b_valid && brdy;
            blk  = bus.b_valid && areq && !st;
            if (bus.sb_set && bus.sb_set_addr != 0 && m_busy[bus.sb_set_addr])
                m_err = 1'b1;
            if (bacc && bus.b_addr != 0)
                m_busy[bus.b_addr] = 1'b0;
            if (bus.sb_set && bus.sb_set_addr != 0)
                m_busy[bus.sb_set_addr] = 1'b1;
            m_run = st ? 0 : (blk ? m_run + 1 : 0);
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        bit          st, areq;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        st     = m_stall();
        areq   = bus.a_wr && bus.a_addr != 0;
        e_wr   = 1'b0;
        e_addr = 5'd0;
        e_data = 32'd0;
        if (st) begin
            if (bus.b_valid) begin
                e_wr = 1'b1; e_addr = bus.b_addr; e_data = bus.b_data;
            end
        end else if (areq) begin
            e_wr = 1'b1; e_addr = bus.a_addr; e_data = bus.a_data;
        end else if (bus.b_valid) begin
            e_wr = 1'b1; e_addr = bus.b_addr; e_data = bus.b_data;
        end
        chk("model_wr",         32'(bus.wr),         32'(e_wr));
        chk("model_addr3",      32'(bus.addr3),      32'(e_addr));
        chk("model_data3",      bus.data3,           e_data);
        chk("model_b_ready",    32'(bus.b_ready),    32'(st || !areq));
        chk("model_pipe_stall", 32'(bus.pipe_stall), 32'(st));
        chk("model_sb_err",     32'(bus.sb_err),     32'(m_err));
        chk("model_hazard1",    32'(bus.hazard1),    32'(bus.q_addr1 != 0 && m_busy[bus.q_addr1]));
        chk("model_hazard2",    32'(bus.hazard2),    32'(bus.q_addr2 != 0 && m_busy[bus.q_addr2]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.a_wr = 0; bus.a_addr = 0; bus.a_data = 0;
        bus.b_valid = 0; bus.b_addr = 0; bus.b_data = 0;
        bus.sb_set = 0; bus.sb_set_addr = 0;
        bus.q_addr1 = 0; bus.q_addr2 = 0;
    endtask

    initial begin
        int stalls;
        clear_inputs();
        tick();
        tick();
        @(negedge clk);
        chk("rst_wr",         32'(bus.wr),         32'd0);
        chk("rst_b_ready",    32'(bus.b_ready),    32'd1);
        chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rst_hazard1",    32'(bus.hazard1),    32'd0);
        chk("rst_sb_err",     32'(bus.sb_err),     32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Priority: pipeline beats mul/div.
        bus.a_wr = 1; bus.a_addr = 5; bus.a_data = 32'h11;
        bus.b_valid = 1; bus.b_addr = 7; bus.b_data = 32'h77;
        @(negedge clk);
        chk("pri_wr",      32'(bus.wr),      32'd1);
        chk("pri_addr3",   32'(bus.addr3),   32'd5);
        chk("pri_data3",   bus.data3,        32'h11);
        chk("pri_b_ready", 32'(bus.b_ready), 32'd0);
        tick();
        bus.a_wr = 0;
        @(negedge clk);
        chk("pri2_addr3",   32'(bus.addr3),   32'd7);
        chk("pri2_b_ready", 32'(bus.b_ready), 32'd1);
        tick();
        clear_inputs();

        // Scoreboard set / hazard / clear.
        bus.sb_set = 1; bus.sb_set_addr = 8; bus.q_addr1 = 8; bus.q_addr2 = 0;
        @(negedge clk);
        chk("sb_hz_before", 32'(bus.hazard1), 32'd0);
        tick();
        bus.sb_set = 0;
        @(negedge clk);
        chk("sb_hz_set",  32'(bus.hazard1), 32'd1);
        chk("sb_hz_zero", 32'(bus.hazard2), 32'd0);
        bus.b_valid = 1; bus.b_addr = 8; bus.b_data = 32'h88;
        tick();
        bus.b_valid = 0;
        @(negedge clk);
        chk("sb_hz_clr", 32'(bus.hazard1), 32'd0);
        tick();

        // Starvation with LIMIT=4.
        bus.a_wr = 1; bus.a_addr = 3; bus.a_data = 32'h33;
        bus.b_valid = 1; bus.b_addr = 9; bus.b_data = 32'h99;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge clk);
            chk("starve_b_ready", 32'(bus.b_ready),    32'd0);
            chk("starve_stall",   32'(bus.pipe_stall), 32'd0);
            tick();
        end
        @(negedge clk);
        chk("force_stall",   32'(bus.pipe_stall), 32'd1);
        chk("force_addr3",   32'(bus.addr3),      32'd9);
        chk("force_b_ready", 32'(bus.b_ready),    32'd1);
        tick();
        bus.b_valid = 0;
        @(negedge clk);
        chk("after_addr3", 32'(bus.addr3),      32'd3);
        chk("after_stall", 32'(bus.pipe_stall), 32'd0);
        tick();

        // Continuous contention: stalls land on cycles 4 and 9 of 10.
        bus.b_valid = 1;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.pipe_stall) stalls++;
            tick();
        end
        chk("stall_count", 32'(stalls), 32'd2);
        clear_inputs();
        tick();

        // Same-cycle set and clear of r9, then duplicate reservation.
        bus.sb_set = 1; bus.sb_set_addr = 9;
        bus.b_valid = 1; bus.b_addr = 9; bus.b_data = 32'h5;
        tick();
        clear_inputs();
        bus.q_addr1 = 9;
        @(negedge clk);
        chk("setclr_hazard", 32'(bus.hazard1), 32'd1);
        chk("setclr_err",    32'(bus.sb_err),  32'd0);
        bus.sb_set = 1; bus.sb_set_addr = 9;
        tick();
        bus.sb_set = 0;
        tick();
        tick();
        @(negedge clk);
        chk("dup_err_sticky", 32'(bus.sb_err),  32'd1);
        chk("dup_hazard",     32'(bus.hazard1), 32'd1);
        tick();

        // Async reset during FORCE with r4 reserved.
        bus.sb_set = 1; bus.sb_set_addr = 4;
        tick();
        bus.sb_set = 0;
        bus.q_addr2 = 4;
        bus.a_wr = 1; bus.a_addr = 3; bus.a_data = 32'h3;
        bus.b_valid = 1; bus.b_addr = 5; bus.b_data = 32'h55;
        for (int i = 0; i < LIMIT; i++) tick();
        @(negedge clk);
        chk("pre_rst_stall",  32'(bus.pipe_stall), 32'd1);
        chk("pre_rst_hazard", 32'(bus.hazard2),    32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_stall",  32'(bus.pipe_stall), 32'd0);
        chk("async_hazard", 32'(bus.hazard2),    32'd0);
        chk("async_err",    32'(bus.sb_err),     32'd0);
        chk("async_hz1",    32'(bus.hazard1),    32'd0);
        tick();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
